// File: rtl/ultra_axil_pkg.sv
// Shared AXI4-lite widths and the slave FSM state encoding.
package ultra_axil_pkg;

    localparam int AXIL_DW = 32;
    localparam int AXIL_AW = 32;
    localparam int AXIL_SW = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_ADDR = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_RESP = 3'd5
    } axil_slv_state_e;

endpackage

// File: rtl/sram_bytewen.sv
// 1R1W synchronous word array with per-byte write enables and a registered read port.
module sram_bytewen
    import ultra_axil_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [AXIL_DW-1:0]    wr_data,
    input  logic [AXIL_SW-1:0]    wr_strb,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [AXIL_DW-1:0]    rd_data
);

    logic [AXIL_DW-1:0] mem_r [2**DEPTH_LOG2];
    logic [AXIL_DW-1:0] rd_data_r;

    // byte-masked write port; contents deliberately have no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < AXIL_SW; i++) begin
            if (wr_en && wr_strb[i]) begin
                mem_r[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // registered read port, holds its value while rd_en is low
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-lite slave over a byte-writable SRAM; one transaction in flight, AW/W in either order,
// read data returned RD_LAT cycles after the AR handshake.
module axil_sram_slave
    import ultra_axil_pkg::*;
#(
    parameter int                 DEPTH_LOG2 = 10,
    parameter logic [AXIL_AW-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int                 RD_LAT     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               axi_awvalid,
    output logic               axi_awready,
    input  logic [AXIL_AW-1:0] axi_awaddr,
    input  logic               axi_wvalid,
    output logic               axi_wready,
    input  logic [AXIL_DW-1:0] axi_wdata,
    input  logic [AXIL_SW-1:0] axi_wstrb,
    output logic               axi_bvalid,
    input  logic               axi_bready,
    input  logic               axi_arvalid,
    output logic               axi_arready,
    input  logic [AXIL_AW-1:0] axi_araddr,
    output logic               axi_rvalid,
    input  logic               axi_rready,
    output logic [AXIL_DW-1:0] axi_rdata
);

    localparam int CNT_W = 3;

    function automatic logic in_range(input logic [AXIL_AW-1:0] addr);
        return (addr >> (DEPTH_LOG2 + 2)) == (BASE_ADDR >> (DEPTH_LOG2 + 2));
    endfunction

    axil_slv_state_e       state_r, state_next_s;
    logic [AXIL_AW-1:0]    aw_addr_r;
    logic [AXIL_DW-1:0]    w_data_r;
    logic [AXIL_SW-1:0]    w_strb_r;
    logic [AXIL_AW-1:0]    ar_addr_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  bvalid_r, rvalid_r;
    logic [AXIL_DW-1:0]    rdata_r;
    logic                  awready_s, wready_s, arready_s, commit_s, rd_en_s;
    logic [AXIL_AW-1:0]    wr_addr_s, rd_addr_s;
    logic [AXIL_DW-1:0]    wr_data_s, sram_q_s;
    logic [AXIL_SW-1:0]    wr_strb_s;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // next-state logic; a pending write always beats a read in IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (axi_awvalid && axi_wvalid) state_next_s = ST_WR_RESP;
                else if (axi_awvalid)          state_next_s = ST_WR_DATA;
                else if (axi_wvalid)           state_next_s = ST_WR_ADDR;
                else if (axi_arvalid)          state_next_s = ST_RD_WAIT;
                else                           state_next_s = ST_IDLE;
            end
            ST_WR_DATA: state_next_s = axi_wvalid  ? ST_WR_RESP : ST_WR_DATA;
            ST_WR_ADDR: state_next_s = axi_awvalid ? ST_WR_RESP : ST_WR_ADDR;
            ST_WR_RESP: state_next_s = axi_bready  ? ST_IDLE    : ST_WR_RESP;
            ST_RD_WAIT: state_next_s = (cnt_r == '0) ? ST_RD_RESP : ST_RD_WAIT;
            ST_RD_RESP: state_next_s = axi_rready  ? ST_IDLE    : ST_RD_RESP;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // readies, write commit and SRAM operand selection
    always_comb begin
        awready_s = (state_r == ST_IDLE) || (state_r == ST_WR_ADDR);
        wready_s  = (state_r == ST_IDLE) || (state_r == ST_WR_DATA);
        arready_s = (state_r == ST_IDLE) && !axi_awvalid && !axi_wvalid;
        commit_s  = 1'b0;
        wr_addr_s = axi_awaddr;
        wr_data_s = axi_wdata;
        wr_strb_s = axi_wstrb;
        case (state_r)
            ST_IDLE:    commit_s = axi_awvalid && axi_wvalid;
            ST_WR_DATA: begin
                commit_s  = axi_wvalid;
                wr_addr_s = aw_addr_r;
            end
            ST_WR_ADDR: begin
                commit_s  = axi_awvalid;
                wr_data_s = w_data_r;
                wr_strb_s = w_strb_r;
            end
            default:    commit_s = 1'b0;
        endcase
        // the read is issued at the AR handshake and re-issued while waiting
        if (state_r == ST_IDLE) begin
            rd_addr_s = axi_araddr;
        end else begin
            rd_addr_s = ar_addr_r;
        end
        rd_en_s = (state_r == ST_IDLE) || (state_r == ST_RD_WAIT);
    end

    // holding registers, latency counter and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_addr_r <= 32'h0000_0000;
            w_data_r  <= 32'h0000_0000;
            w_strb_r  <= 4'h0;
            ar_addr_r <= 32'h0000_0000;
            cnt_r     <= 3'd0;
            bvalid_r  <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
        end else begin
            bvalid_r <= (state_next_s == ST_WR_RESP);
            rvalid_r <= (state_next_s == ST_RD_RESP);
            if (state_r == ST_IDLE && axi_awvalid && !axi_wvalid) begin
                aw_addr_r <= axi_awaddr;
            end
            if (state_r == ST_IDLE && axi_wvalid && !axi_awvalid) begin
                w_data_r <= axi_wdata;
                w_strb_r <= axi_wstrb;
            end
            if (arready_s && axi_arvalid) begin
                ar_addr_r <= axi_araddr;
                cnt_r     <= CNT_W'(RD_LAT - 1);
            end else if (state_r == ST_RD_WAIT && cnt_r != 3'd0) begin
                cnt_r <= cnt_r - 3'd1;
            end
            if (state_r == ST_RD_WAIT && cnt_r == 3'd0) begin
                rdata_r <= in_range(ar_addr_r) ? sram_q_s : 32'h0000_0000;
            end
        end
    end

    sram_bytewen #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
        .clk     (clk),
        .wr_en   (commit_s && in_range(wr_addr_s)),
        .wr_addr (wr_addr_s[DEPTH_LOG2+1:2]),
        .wr_data (wr_data_s),
        .wr_strb (wr_strb_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s[DEPTH_LOG2+1:2]),
        .rd_data (sram_q_s)
    );

    assign axi_awready = awready_s;
    assign axi_wready  = wready_s;
    assign axi_arready = arready_s;
    assign axi_bvalid  = bvalid_r;
    assign axi_rvalid  = rvalid_r;
    assign axi_rdata   = rdata_r;

endmodule
